// File: rtl/loctag_pkg.sv
// Shared types and helpers for the loctag MAC scheduler: FSM state encoding,
// LFSR feedback mask, statistics width and the saturating counter step.
package loctag_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_WAIT = 3'd2,
        ST_TX   = 3'd3,
        ST_HOLD = 3'd4
    } mac_state_t;

    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam int          STAT_W    = 16;

    // Right-shifting Galois step; the mask is folded in when the bit shifted out is 1.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? LFSR_MASK : 16'h0000);
    endfunction

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/loctag_mac_scheduler_if.sv
// Bundle between trigger/mode logic, the MAC scheduler and the reflector modulator.
// The master modport is the scheduler side.
interface loctag_mac_scheduler_if #(
    parameter int MAC_Q = 2
);
    import loctag_pkg::*;

    logic              enable;
    logic              trig;
    logic              force_fs;
    logic              tx_start;
    logic [MAC_Q-1:0]  tx_slot;
    logic              tx_done;
    logic              tx_ok;
    logic              busy;
    logic [STAT_W-1:0] stat_ok;
    logic [STAT_W-1:0] stat_fail;
    logic [STAT_W-1:0] stat_drop;

    modport master (
        input  enable, trig, force_fs, tx_done, tx_ok,
        output tx_start, tx_slot, busy, stat_ok, stat_fail, stat_drop
    );

    modport slave (
        output enable, trig, force_fs, tx_done, tx_ok,
        input  tx_start, tx_slot, busy, stat_ok, stat_fail, stat_drop
    );

endinterface

// File: rtl/loctag_lfsr16.sv
// Free-running 16-bit Galois LFSR used to draw transmit slots.
// An all-zero seed would lock up, so it is replaced by 16'h0001.
module loctag_lfsr16
    import loctag_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hF1B7
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] value
);

    localparam logic [15:0] LOAD = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] lfsr_r;

    // Shift every cycle regardless of scheduler state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_r <= LOAD;
        end else begin
            lfsr_r <= lfsr_step(lfsr_r);
        end
    end

    assign value = lfsr_r;

endmodule

// File: rtl/loctag_mac_scheduler.sv
// Slotted-ALOHA scheduler: a trigger edge opens a frame of 2^MAC_Q slots, one tx_start
// fires in a drawn slot, failures retry in fresh frames. Optional macro MAC_STATS_EN adds counters.
module loctag_mac_scheduler
    import loctag_pkg::*;
#(
    parameter logic [15:0] MAC_SEED     = 16'hF1B7,
    parameter int          MAC_Q        = 2,
    parameter logic [15:0] SLOT_CYCLES  = 16'd2400,
    parameter logic [15:0] GUARD_CYCLES = 16'd48,
    parameter int          MAX_RETRY    = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    loctag_mac_scheduler_if.master bus
);

    localparam logic [MAC_Q-1:0] SLOT_LAST = {MAC_Q{1'b1}};
    localparam logic [MAC_Q-1:0] SLOT_ONE  = MAC_Q'(1'b1);
    localparam logic [15:0]      CYC_LAST  = SLOT_CYCLES - 16'd1;
    localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);

    mac_state_t       state_r, state_s, cont_s;
    logic [15:0]      cyc_cnt_r, cyc_cnt_s;
    logic [MAC_Q-1:0] slot_cnt_r, slot_cnt_s;
    logic [MAC_Q-1:0] tx_slot_r, tx_slot_s;
    logic [3:0]       retry_cnt_r, retry_cnt_s;
    logic             res_ok_r, res_ok_s;
    logic             tx_start_r, tx_start_s;
    logic             busy_r;
    logic             trig_d_r;
    logic [15:0]      lfsr_s;
    logic             edge_s, frame_end_s, retry_left_s, resolve_s, outcome_ok_s;

    loctag_lfsr16 #(.SEED(MAC_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .value (lfsr_s)
    );

    assign edge_s       = bus.trig & ~trig_d_r;
    assign frame_end_s  = (slot_cnt_r == SLOT_LAST) && (cyc_cnt_r == CYC_LAST);
    assign retry_left_s = (retry_cnt_r < RETRY_MAX);

    // Next-state, frame counters and tx_start lookahead.
    always_comb begin
        cont_s       = state_r;
        state_s      = state_r;
        cyc_cnt_s    = cyc_cnt_r;
        slot_cnt_s   = slot_cnt_r;
        tx_slot_s    = tx_slot_r;
        retry_cnt_s  = retry_cnt_r;
        res_ok_s     = res_ok_r;
        resolve_s    = 1'b0;
        outcome_ok_s = 1'b0;

        if (state_r == ST_WAIT || state_r == ST_TX || state_r == ST_HOLD) begin
            if (cyc_cnt_r == CYC_LAST) begin
                cyc_cnt_s  = 16'd0;
                slot_cnt_s = slot_cnt_r + SLOT_ONE;
            end else begin
                cyc_cnt_s  = cyc_cnt_r + 16'd1;
                slot_cnt_s = slot_cnt_r;
            end
        end else begin
            cyc_cnt_s  = cyc_cnt_r;
            slot_cnt_s = slot_cnt_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (edge_s && bus.enable) begin
                    cont_s      = ST_ARM;
                    retry_cnt_s = 4'd0;
                end else begin
                    cont_s = ST_IDLE;
                end
            end
            ST_ARM: begin
                tx_slot_s  = bus.force_fs ? {MAC_Q{1'b0}} : lfsr_s[MAC_Q-1:0];
                cyc_cnt_s  = 16'd0;
                slot_cnt_s = {MAC_Q{1'b0}};
                cont_s     = ST_WAIT;
            end
            ST_WAIT: begin
                cont_s = tx_start_r ? ST_TX : ST_WAIT;
            end
            ST_TX: begin
                // A tx_done landing in the frame-end cycle is a result, not an abort.
                outcome_ok_s = bus.tx_done & bus.tx_ok;
                if (frame_end_s) begin
                    resolve_s = 1'b1;
                end else if (bus.tx_done) begin
                    res_ok_s = bus.tx_ok;
                    cont_s   = ST_HOLD;
                end else begin
                    cont_s = ST_TX;
                end
            end
            ST_HOLD: begin
                outcome_ok_s = res_ok_r;
                resolve_s    = frame_end_s;
                cont_s       = ST_HOLD;
            end
            default: begin
                cont_s = ST_IDLE;
            end
        endcase

        if (resolve_s) begin
            if (outcome_ok_s || !retry_left_s) begin
                state_s = ST_IDLE;
            end else begin
                state_s     = ST_ARM;
                retry_cnt_s = retry_cnt_r + 4'd1;
            end
        end else begin
            state_s = cont_s;
        end

        tx_start_s = (state_s == ST_WAIT) && (cyc_cnt_s == GUARD_CYCLES) && (slot_cnt_s == tx_slot_s);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cyc_cnt_r   <= 16'd0;
            slot_cnt_r  <= {MAC_Q{1'b0}};
            tx_slot_r   <= {MAC_Q{1'b0}};
            retry_cnt_r <= 4'd0;
            res_ok_r    <= 1'b0;
            tx_start_r  <= 1'b0;
            busy_r      <= 1'b0;
            trig_d_r    <= 1'b0;
        end else begin
            state_r     <= state_s;
            cyc_cnt_r   <= cyc_cnt_s;
            slot_cnt_r  <= slot_cnt_s;
            tx_slot_r   <= tx_slot_s;
            retry_cnt_r <= retry_cnt_s;
            res_ok_r    <= res_ok_s;
            tx_start_r  <= tx_start_s;
            busy_r      <= (state_s != ST_IDLE);
            trig_d_r    <= bus.trig;
        end
    end

    assign bus.tx_start = tx_start_r;
    assign bus.tx_slot  = tx_slot_r;
    assign bus.busy     = busy_r;

`ifdef MAC_STATS_EN
    logic [STAT_W-1:0] stat_ok_r, stat_fail_r, stat_drop_r;

    // Saturating outcome and dropped-trigger counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_ok_r   <= 16'd0;
            stat_fail_r <= 16'd0;
            stat_drop_r <= 16'd0;
        end else begin
            if (resolve_s && outcome_ok_s) begin
                stat_ok_r <= sat_inc(stat_ok_r);
            end else begin
                stat_ok_r <= stat_ok_r;
            end
            if (resolve_s && !outcome_ok_s && !retry_left_s) begin
                stat_fail_r <= sat_inc(stat_fail_r);
            end else begin
                stat_fail_r <= stat_fail_r;
            end
            if (edge_s && (state_r != ST_IDLE)) begin
                stat_drop_r <= sat_inc(stat_drop_r);
            end else begin
                stat_drop_r <= stat_drop_r;
            end
        end
    end

    assign bus.stat_ok   = stat_ok_r;
    assign bus.stat_fail = stat_fail_r;
    assign bus.stat_drop = stat_drop_r;
`else
    assign bus.stat_ok   = 16'h0000;
    assign bus.stat_fail = 16'h0000;
    assign bus.stat_drop = 16'h0000;
`endif

endmodule

// File: tb/tb_loctag_mac_scheduler.sv
// Directed bench for loctag_mac_scheduler with SLOT_CYCLES=100, GUARD_CYCLES=4, MAC_Q=2.
// Expected stat values collapse to zero when MAC_STATS_EN is not defined.
module tb_loctag_mac_scheduler;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_start = 0;
    int   last_start = 0;
    logic [15:0] lfsr_m;
    logic [1:0]  exp_slot;
    int   e, t;

    loctag_mac_scheduler_if #(.MAC_Q(2)) bus ();

    loctag_mac_scheduler #(
        .MAC_SEED     (16'hF1B7),
        .MAC_Q        (2),
        .SLOT_CYCLES  (16'd100),
        .GUARD_CYCLES (16'd4),
        .MAX_RETRY    (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference LFSR: right shift, feedback mask B400 when the dropped bit is 1.
    always @(posedge clk or posedge reset) begin
        if (reset) lfsr_m <= 16'hF1B7;
        else       lfsr_m <= (lfsr_m >> 1) ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
    end

    always @(negedge clk) begin
        if (bus.tx_start === 1'b1) begin
            n_start    <= n_start + 1;
            last_start <= cyc;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] sx(input int v);
`ifdef MAC_STATS_EN
        return v;
`else
        return 32'd0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_done(input logic ok);
        bus.tx_done = 1'b1;
        bus.tx_ok   = ok;
        goto(cyc + 1);
        bus.tx_done = 1'b0;
        bus.tx_ok   = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.enable = 1'b0; bus.trig = 1'b0; bus.force_fs = 1'b0;
        bus.tx_done = 1'b0; bus.tx_ok = 1'b0;
        goto(3);
        chk("rst_busy", bus.busy, 32'd0);
        chk("rst_tx_start", bus.tx_start, 32'd0);
        chk("rst_tx_slot", bus.tx_slot, 32'd0);
        chk("rst_stat_ok", bus.stat_ok, 32'd0);
        chk("rst_stat_fail", bus.stat_fail, 32'd0);
        chk("rst_stat_drop", bus.stat_drop, 32'd0);
        reset = 1'b0;
        bus.enable = 1'b1;

        // Forced first slot, success at +40
        e = 10;
        goto(e); bus.force_fs = 1'b1; bus.trig = 1'b1;
        goto(e + 5); chk("t1_pre_start", bus.tx_start, 32'd0);
        goto(e + 6); chk("t1_start", bus.tx_start, 32'd1);
        chk("t1_slot", bus.tx_slot, 32'd0);
        chk("t1_busy", bus.busy, 32'd1);
        goto(e + 7); chk("t1_start_one_cycle", bus.tx_start, 32'd0);
        goto(e + 8); bus.trig = 1'b0;
        goto(e + 40); pulse_done(1'b1);
        goto(e + 401); chk("t1_busy_frame_end", bus.busy, 32'd1);
        goto(e + 402); chk("t1_idle", bus.busy, 32'd0);
        chk("t1_stat_ok", bus.stat_ok, sx(1));
        chk("t1_n_start", n_start, 32'd1);

        // Random slot drawn from the LFSR in the ARM cycle
        e = 500;
        goto(e); bus.force_fs = 1'b0; bus.trig = 1'b1;
        goto(e + 1); exp_slot = lfsr_m[1:0];
        goto(e + 2); bus.trig = 1'b0;
        chk("t2_slot", bus.tx_slot, {30'd0, exp_slot});
        t = e + 6 + int'(exp_slot) * 100;
        goto(t - 1); chk("t2_pre_start", bus.tx_start, 32'd0);
        goto(t); chk("t2_start", bus.tx_start, 32'd1);
        goto(t + 5); pulse_done(1'b1);
        goto(e + 402); chk("t2_idle", bus.busy, 32'd0);
        chk("t2_n_start", n_start, 32'd2);

        // Every attempt fails: 1 + 3 retries, one frame each
        e = 1000;
        goto(e); bus.force_fs = 1'b1; bus.trig = 1'b1;
        goto(e + 2); bus.trig = 1'b0;
        for (int k = 0; k < 4; k++) begin
            goto(e + 6 + 401 * k);
            chk($sformatf("t3_start%0d", k), bus.tx_start, 32'd1);
            goto(e + 9 + 401 * k); pulse_done(1'b0);
        end
        goto(e + 1604); chk("t3_busy_last_frame", bus.busy, 32'd1);
        goto(e + 1605); chk("t3_idle", bus.busy, 32'd0);
        chk("t3_n_start", n_start, 32'd6);
        chk("t3_stat_fail", bus.stat_fail, sx(1));
        chk("t3_stat_ok", bus.stat_ok, sx(2));

        // No tx_done: abort at frame end, retry frame starts next cycle
        e = 3000;
        goto(e); bus.trig = 1'b1;
        goto(e + 2); bus.trig = 1'b0;
        goto(e + 6); chk("t4_start0", bus.tx_start, 32'd1);
        goto(e + 401); chk("t4_busy_abort", bus.busy, 32'd1);
        goto(e + 406); chk("t4_pre_start1", bus.tx_start, 32'd0);
        goto(e + 407); chk("t4_start1", bus.tx_start, 32'd1);
        goto(e + 410); pulse_done(1'b1);
        goto(e + 802); chk("t4_busy_frame2", bus.busy, 32'd1);
        goto(e + 803); chk("t4_idle", bus.busy, 32'd0);
        chk("t4_n_start", n_start, 32'd8);
        chk("t4_stat_ok", bus.stat_ok, sx(3));
        chk("t4_stat_fail", bus.stat_fail, sx(1));

        // Second edge mid-frame dropped; stray tx_done in HOLD ignored; enable low ignores edges
        e = 4000;
        goto(e); bus.trig = 1'b1;
        goto(e + 2); bus.trig = 1'b0;
        goto(e + 10); pulse_done(1'b1);
        goto(e + 50); bus.trig = 1'b1;
        goto(e + 52); bus.trig = 1'b0;
        goto(e + 100); pulse_done(1'b0);
        goto(e + 402); chk("t5_idle", bus.busy, 32'd0);
        chk("t5_n_start", n_start, 32'd9);
        chk("t5_stat_drop", bus.stat_drop, sx(1));
        chk("t5_stat_ok", bus.stat_ok, sx(4));
        chk("t5_stat_fail", bus.stat_fail, sx(1));
        bus.enable = 1'b0;
        goto(e + 410); bus.trig = 1'b1;
        goto(e + 412); chk("t5_disabled_busy", bus.busy, 32'd0);
        bus.trig = 1'b0;
        chk("t5_disabled_drop", bus.stat_drop, sx(1));
        bus.enable = 1'b1;

        // Reset one cycle before tx_start
        e = 5000;
        goto(e); bus.trig = 1'b1;
        goto(e + 2); bus.trig = 1'b0;
        goto(e + 5); chk("t6_pre_start", bus.tx_start, 32'd0);
        reset = 1'b1;
        #1;
        chk("t6_busy_async", bus.busy, 32'd0);
        goto(e + 8); reset = 1'b0;
        goto(e + 40); chk("t6_no_start", n_start, 32'd9);
        chk("t6_stat_ok_cleared", bus.stat_ok, 32'd0);

        // LFSR reloaded: draw must follow the reference seeded at reset
        e = 5060;
        goto(e); bus.force_fs = 1'b0; bus.trig = 1'b1;
        goto(e + 1); exp_slot = lfsr_m[1:0];
        goto(e + 2); bus.trig = 1'b0;
        chk("t6_slot", bus.tx_slot, {30'd0, exp_slot});
        t = e + 6 + int'(exp_slot) * 100;
        goto(t); chk("t6_start", bus.tx_start, 32'd1);
        chk("t6_start_time", last_start, t);
        goto(t + 3); pulse_done(1'b1);
        goto(e + 402); chk("t6_idle", bus.busy, 32'd0);
        chk("t6_stat_ok", bus.stat_ok, sx(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
